// File: rtl/q_stream_monitor_pkg.sv
// q_stream_monitor_pkg: shared FSM state type and default counter width for the stream monitor.
package q_stream_monitor_pkg;
    typedef enum logic {WARMUP, RUN} state_e;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/q_stream_monitor_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/q_stream_monitor.sv
// q_stream_monitor: watches a flip-flop's q/qn pair for edges, complement faults and a bit pattern.
// Define Q_STREAM_MONITOR_RUNLEN_EN to build the longest-run tracker behind max_run.
module q_stream_monitor
    import q_stream_monitor_pkg::*;
#(
    parameter logic [7:0] PATTERN = 8'b1011_0000,
    parameter int         PAT_LEN = 4,
    parameter int         CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q,
    input  logic             qn,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             comp_err,
    output logic [CNT_W-1:0] max_run
);
    localparam logic [PAT_LEN-1:0] PAT  = PATTERN[7 -: PAT_LEN];
    localparam logic [3:0]         LAST = 4'(PAT_LEN - 1);
    state_e state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic match_q, match_d, comp_err_q, comp_err_d;
    logic have, full, same, err, rise, fall;
    // hist_q[0] is the previous sample; have says whether one exists since reset/clear
    always_comb begin
        have       = (state_q == RUN) || (wcnt_q != 4'd0);
        full       = (state_q == RUN) || (wcnt_q == LAST);
        same       = have && (q == hist_q[0]);
        err        = !clear && (qn == q);
        rise       = !clear && have && !hist_q[0] && q;
        fall       = !clear && have && hist_q[0] && !q;
        hist_d     = clear ? '0 : PAT_LEN'({hist_q, q});
        match_d    = !clear && full && (hist_d == PAT);
        comp_err_d = !clear && (comp_err_q || err);
        state_d    = clear ? WARMUP : full ? RUN : state_q;
        wcnt_d     = clear ? 4'd0 : (state_q == WARMUP) ? wcnt_q + 4'd1 : wcnt_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= WARMUP;
            wcnt_q     <= 4'd0;
            hist_q     <= '0;
            match_q    <= 1'b0;
            comp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            hist_q     <= hist_d;
            match_q    <= match_d;
            comp_err_q <= comp_err_d;
        end
    sat_counter #(.W(CNT_W)) u_rise (.clk(clk), .rst_n(rst_n), .inc(rise), .clr(clear), .cnt(rise_cnt));
    sat_counter #(.W(CNT_W)) u_fall (.clk(clk), .rst_n(rst_n), .inc(fall), .clr(clear), .cnt(fall_cnt));
    sat_counter #(.W(CNT_W)) u_err  (.clk(clk), .rst_n(rst_n), .inc(err),  .clr(clear), .cnt(err_cnt));
    assign match    = match_q;
    assign comp_err = comp_err_q;
`ifdef Q_STREAM_MONITOR_RUNLEN_EN
    // u_run holds the current run length minus one, so a fresh run is a plain clear
    logic [CNT_W-1:0] extra_cnt, max_run_q, max_run_d;
    logic [CNT_W:0]   run_len;
    sat_counter #(.W(CNT_W)) u_run (
        .clk(clk), .rst_n(rst_n), .inc(!clear && same), .clr(clear || !same), .cnt(extra_cnt)
    );
    always_comb begin
        run_len   = same ? {1'b0, extra_cnt} + (CNT_W + 1)'(2) : (CNT_W + 1)'(1);
        max_run_d = clear ? '0
                  : (run_len > {1'b0, max_run_q}) ? (run_len[CNT_W] ? '1 : run_len[CNT_W-1:0])
                  : max_run_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) max_run_q <= '0;
        else max_run_q <= max_run_d;
    assign max_run = max_run_q;
`else
    assign max_run = '0;
`endif
endmodule

// File: tb/tb_q_stream_monitor.sv
// tb_q_stream_monitor: directed plus random stimulus against a sample-history reference model.
module tb_q_stream_monitor;
    localparam logic [7:0] PAT  = 8'b1011_0000;
    localparam int         PLEN = 4;

    logic clk = 1'b0, rst_n = 1'b0, q = 1'b0, qn = 1'b1, clear = 1'b0;
    logic        match_a, comp_err_a, match_b, comp_err_b;
    logic [15:0] rise_a, fall_a, err_a, max_a;
    logic [3:0]  rise_b, fall_b, err_b, max_b;

    q_stream_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .q(q), .qn(qn), .clear(clear), .match(match_a),
        .rise_cnt(rise_a), .fall_cnt(fall_a), .err_cnt(err_a), .comp_err(comp_err_a), .max_run(max_a)
    );
    q_stream_monitor #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .q(q), .qn(qn), .clear(clear), .match(match_b),
        .rise_cnt(rise_b), .fall_cnt(fall_b), .err_cnt(err_b), .comp_err(comp_err_b), .max_run(max_b)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    bit hist[$];
    int m_rise, m_fall, m_err, m_run, m_best;
    bit m_cerr, m_match;

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        m_rise = 0; m_fall = 0; m_err = 0; m_run = 0; m_best = 0;
        m_cerr = 0; m_match = 0;
    endtask

    task automatic model_sample(input bit qv, input bit qnv, input bit clr);
        int n;
        if (clr) begin
            model_reset();
            return;
        end
        if (hist.size() > 0 && hist[hist.size() - 1] != qv) begin
            if (qv) m_rise++; else m_fall++;
            m_run = 1;
        end else m_run = (hist.size() > 0) ? m_run + 1 : 1;
        if (m_run > m_best) m_best = m_run;
        if (qnv == qv) begin
            m_err++;
            m_cerr = 1;
        end
        hist.push_back(qv);
        n = hist.size();
        m_match = (n >= PLEN);
        for (int i = 0; i < PLEN; i++)
            if (n >= PLEN && hist[n - PLEN + i] != PAT[7 - i]) m_match = 0;
    endtask

    task automatic check_all();
        int exp_max_a, exp_max_b;
`ifdef Q_STREAM_MONITOR_RUNLEN_EN
        exp_max_a = sat(m_best, 16);
        exp_max_b = sat(m_best, 4);
`else
        exp_max_a = 0;
        exp_max_b = 0;
`endif
        chk("a.match", 32'(match_a), 32'(m_match));
        chk("a.rise_cnt", 32'(rise_a), sat(m_rise, 16));
        chk("a.fall_cnt", 32'(fall_a), sat(m_fall, 16));
        chk("a.err_cnt", 32'(err_a), sat(m_err, 16));
        chk("a.comp_err", 32'(comp_err_a), 32'(m_cerr));
        chk("a.max_run", 32'(max_a), exp_max_a);
        chk("b.match", 32'(match_b), 32'(m_match));
        chk("b.rise_cnt", 32'(rise_b), sat(m_rise, 4));
        chk("b.fall_cnt", 32'(fall_b), sat(m_fall, 4));
        chk("b.err_cnt", 32'(err_b), sat(m_err, 4));
        chk("b.comp_err", 32'(comp_err_b), 32'(m_cerr));
        chk("b.max_run", 32'(max_b), exp_max_b);
    endtask

    task automatic step(input bit qv, input bit qnv, input bit clr);
        q = qv; qn = qnv; clear = clr;
        @(posedge clk);
        model_sample(qv, qnv, clr);
        #1 check_all();
    endtask

    task automatic good(input bit qv);
        step(qv, ~qv, 1'b0);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        model_reset();
        #2 check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12 check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) good(i[0]);
        chk("toggle.edges", 32'(rise_a) + 32'(fall_a), 32'd9);
        step(1'b0, 1'b1, 1'b1);
        good(1); good(0); good(1); good(1); good(0); good(1); good(1);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        chk("comp.err_cnt", 32'(err_a), 32'd3);
        good(0); good(1);
        step(1'b1, 1'b1, 1'b1);
        good(0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) good(i[0]);
        chk("sat.rise_b", 32'(rise_b), 32'd15);
        step(1'b0, 1'b1, 1'b1);
        good(1); good(0); good(1);
        rst_pulse();
        good(1); good(0); good(1);
        chk("rst.no_match", 32'(match_a), 32'd0);
        good(1);
        chk("rst.match", 32'(match_a), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        good(0); good(0); good(0); good(1); good(1); good(0);
        for (int i = 0; i < 20; i++) good(1);
        for (int i = 0; i < 400; i++) begin
            bit qv, bad, clr;
            qv  = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 39) == 0);
            step(qv, bad ? qv : ~qv, clr);
            if ($urandom_range(0, 99) == 0) rst_pulse();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/q_stream_monitor.md
Q_STREAM_MONITOR -- requirements
Module: q_stream_monitor

Interface
REQ-001 Parameter PATTERN, default 8'b1011_0000, match pattern, MSB-first, left-aligned.
REQ-002 Parameter PAT_LEN, default 4, pattern bits used (1..8).
REQ-003 Parameter CNT_W, default 16, width of all counters.
REQ-004 Port clk  input  1  single clock; all state updates on posedge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port q  input  1  flip-flop true output under observation.
REQ-007 Port qn  input  1  flip-flop complement output under observation.
REQ-008 Port clear  input  1  synchronous clear of counters, history and flags.
REQ-009 Port match  output  1  one-cycle pulse on pattern completion.
REQ-010 Port rise_cnt  output  CNT_W  count of 0->1 transitions of sampled q.
REQ-011 Port fall_cnt  output  CNT_W  count of 1->0 transitions of sampled q.
REQ-012 Port err_cnt  output  CNT_W  count of samples with qn != ~q.
REQ-013 Port comp_err  output  1  sticky flag, set on first complement violation.
REQ-014 Port max_run  output  CNT_W  longest run of equal consecutive q samples.

Function
REQ-015 q and qn SHALL be sampled once per posedge clk; every output SHALL be registered and reflect a sample one cycle after it is taken.
REQ-016 FSM states SHALL be WARMUP, RUN; reset and clear SHALL enter WARMUP.
REQ-017 WARMUP SHALL count accepted samples and move to RUN once PAT_LEN samples are held; match SHALL be 0 in WARMUP.
REQ-018 In RUN, match SHALL pulse for one cycle whenever the last PAT_LEN samples, oldest first, equal PATTERN[7 -: PAT_LEN]; overlapping matches SHALL each pulse.
REQ-019 The first sample after reset or clear SHALL NOT count as an edge; later edges compare against the previous sample.
REQ-020 A sample with qn == q SHALL increment err_cnt and set comp_err; the q value SHALL still be used for edges and pattern.
REQ-021 All counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-022 clear asserted with a sample in the same cycle: clear SHALL win; that sample SHALL be discarded.
REQ-023 comp_err SHALL be cleared only by reset or clear.

Reset
REQ-024 rst_n low SHALL asynchronously force: state WARMUP, history 0, match 0, comp_err 0, all counters 0, max_run 0.
REQ-025 Reset asserted mid-stream SHALL discard partial history; deassertion SHALL restart WARMUP with no spurious match or edge.

Configuration
REQ-026 Macro Q_STREAM_MONITOR_RUNLEN_EN defined: max_run SHALL track the longest run (first sample = run 1), saturating, updated when the current run exceeds it.
REQ-027 Macro undefined: run logic SHALL be absent and max_run SHALL be tied to 0.

Structure
REQ-028 Package q_stream_monitor_pkg SHALL hold the FSM state enum and default CNT_W constant.
REQ-029 Sub-module sat_counter (parameter W; inc, clr; saturating) SHALL implement rise, fall, err and run counters.

Verification
REQ-030 Reset, q toggles every cycle with qn=~q for 10 cycles -> rise_cnt+fall_cnt=9, err_cnt=0, comp_err=0.
REQ-031 Default parameters, q stream 1,0,1,1,0,1,1 -> match pulses after 4th and 7th samples (overlap).
REQ-032 Hold q=qn=1 for 3 cycles -> err_cnt=3, comp_err=1 until clear; clear -> all 0, WARMUP.
REQ-033 CNT_W=4, 20 rising edges -> rise_cnt holds 15.
REQ-034 rst_n pulsed low mid-pattern (after 1,0,1) then 1 -> no match; match only after a full new 1011.
REQ-035 With Q_STREAM_MONITOR_RUNLEN_EN, q = 0,0,0,1,1,0 -> max_run=3; without macro -> max_run=0.
